// File: rtl/t_counter.sv
// Up/down modulo counter with parallel load, terminal-count and sticky overflow.
// Latency: q and ovf update one clk edge after the inputs; tc is combinational.
// Backpressure: none; the counter accepts load/en on every edge.
module t_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = longint'(1) << WIDTH,
  parameter bit     SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  // One extra bit so that MODULUS = 2**WIDTH and its neighbours are representable.
  localparam logic [WIDTH:0] LP_MOD = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0] LP_ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] LP_MAX = LP_MOD - LP_ONE;

  // The count register carries the extra bit as well; it is always zero because
  // every value written is below MODULUS, so synthesis trims it away.
  logic [WIDTH:0] r_cnt;
  logic           r_ovf;

  logic [WIDTH:0] w_din_ext;
  logic [WIDTH:0] w_next;
  logic           w_at_max;
  logic           w_at_zero;
  logic           w_tc;

  assign w_din_ext = {1'b0, din};
  assign w_at_max  = (r_cnt == LP_MAX);
  assign w_at_zero = (r_cnt == '0);

  // Terminal count: the enabled step would cross a range end. Reset forces r_cnt
  // to zero, so during reset this naturally reports the q=0 view.
  assign w_tc = en & ~load & ((up & w_at_max) | (~up & w_at_zero));

  // Next count: load (clamped into range) beats count, count beats hold.
  always_comb begin
    w_next = r_cnt;
    if (load) begin
      w_next = (w_din_ext < LP_MOD) ? w_din_ext : LP_MAX;
    end else if (en) begin
      if (up) begin
        if (w_at_max) begin
          w_next = SATURATE ? LP_MAX : '0;
        end else begin
          w_next = r_cnt + LP_ONE;
        end
      end else begin
        if (w_at_zero) begin
          w_next = SATURATE ? '0 : LP_MAX;
        end else begin
          w_next = r_cnt - LP_ONE;
        end
      end
    end
  end

  // Count register; reset discards any update in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

  // Sticky overflow: a range-end event sets it and wins over a same-edge clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_tc) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign q   = r_cnt[WIDTH-1:0];
  assign tc  = w_tc;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_t_counter.sv
// Directed bench for t_counter across four parameter sets.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Each scenario task carries its own hand-computed expected values.
module tb_t_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Default instance: WIDTH=4, MODULUS=16, wrap
  logic       d_en = 0, d_up = 0, d_load = 0, d_clr = 0;
  logic [3:0] d_din = '0;
  logic [3:0] d_q;
  logic       d_tc, d_ovf;
  // WIDTH=4, MODULUS=10, saturate
  logic       s_en = 0, s_up = 0, s_load = 0, s_clr = 0;
  logic [3:0] s_din = '0;
  logic [3:0] s_q;
  logic       s_tc, s_ovf;
  // WIDTH=4, MODULUS=10, wrap
  logic       w_en = 0, w_up = 0, w_load = 0, w_clr = 0;
  logic [3:0] w_din = '0;
  logic [3:0] w_q;
  logic       w_tc, w_ovf;
  // WIDTH=1, MODULUS=2, wrap (T flip-flop)
  logic       t_en = 0, t_up = 0, t_load = 0, t_clr = 0;
  logic [0:0] t_din = '0;
  logic [0:0] t_q;
  logic       t_tc, t_ovf;

  int nvec = 0;
  int nerr = 0;

  t_counter dut_d (
    .clk(clk), .rst(rst), .en(d_en), .up(d_up), .load(d_load), .din(d_din),
    .clr_ovf(d_clr), .q(d_q), .tc(d_tc), .ovf(d_ovf)
  );

  t_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(s_en), .up(s_up), .load(s_load), .din(s_din),
    .clr_ovf(s_clr), .q(s_q), .tc(s_tc), .ovf(s_ovf)
  );

  t_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .en(w_en), .up(w_up), .load(w_load), .din(w_din),
    .clr_ovf(w_clr), .q(w_q), .tc(w_tc), .ovf(w_ovf)
  );

  t_counter #(.WIDTH(1), .MODULUS(2), .SATURATE(1'b0)) dut_t (
    .clk(clk), .rst(rst), .en(t_en), .up(t_up), .load(t_load), .din(t_din),
    .clr_ovf(t_clr), .q(t_q), .tc(t_tc), .ovf(t_ovf)
  );

  initial forever #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    nvec++; if (d_q !== 4'd0) begin nerr++; $display("FAIL reset_d_q: got %0d want 0", d_q); end
    nvec++; if (d_ovf !== 1'b0) begin nerr++; $display("FAIL reset_d_ovf: got %0d want 0", d_ovf); end
    nvec++; if (s_q !== 4'd0) begin nerr++; $display("FAIL reset_s_q: got %0d want 0", s_q); end
    nvec++; if (t_q !== 1'b0) begin nerr++; $display("FAIL reset_t_q: got %0d want 0", t_q); end
    // clk edge with en=1 and load=1 while in reset has no effect
    d_en = 1'b1; d_up = 1'b1; w_load = 1'b1; w_din = 4'd5;
    tick;
    nvec++; if (d_q !== 4'd0) begin nerr++; $display("FAIL reset_edge_en: got %0d want 0", d_q); end
    nvec++; if (w_q !== 4'd0) begin nerr++; $display("FAIL reset_edge_load: got %0d want 0", w_q); end
    nvec++; if (d_tc !== 1'b0) begin nerr++; $display("FAIL reset_tc_up: got %0d want 0", d_tc); end
    d_up = 1'b0;
    #1;
    nvec++; if (d_tc !== 1'b1) begin nerr++; $display("FAIL reset_tc_down: got %0d want 1", d_tc); end
    d_en = 1'b0; w_load = 1'b0;
    #1 rst = 1'b0;
    tick;
  endtask

  task automatic test_wrap;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    d_en = 1'b1; d_up = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #1;
      nvec++; if (d_tc !== ((i % 16) == 15)) begin nerr++; $display("FAIL wrap_tc[%0d]: got %0d want %0d", i, d_tc, ((i % 16) == 15)); end
      tick;
      nvec++; if (int'(d_q) !== ((i + 1) % 16)) begin nerr++; $display("FAIL wrap_q[%0d]: got %0d want %0d", i, d_q, (i + 1) % 16); end
      nvec++; if (d_ovf !== (i >= 15)) begin nerr++; $display("FAIL wrap_ovf[%0d]: got %0d want %0d", i, d_ovf, (i >= 15)); end
    end
    d_en = 1'b0;
  endtask

  task automatic test_clr_ovf;
    // q=1, ovf=1 on entry
    d_load = 1'b1; d_din = 4'd15;
    tick;
    nvec++; if (d_q !== 4'd15) begin nerr++; $display("FAIL clr_load_q: got %0d want 15", d_q); end
    nvec++; if (d_ovf !== 1'b1) begin nerr++; $display("FAIL clr_load_keeps_ovf: got %0d want 1", d_ovf); end
    d_load = 1'b0; d_en = 1'b1; d_up = 1'b1; d_clr = 1'b1;
    #1;
    nvec++; if (d_tc !== 1'b1) begin nerr++; $display("FAIL clr_tc: got %0d want 1", d_tc); end
    tick;
    nvec++; if (d_q !== 4'd0) begin nerr++; $display("FAIL clr_wrap_q: got %0d want 0", d_q); end
    nvec++; if (d_ovf !== 1'b1) begin nerr++; $display("FAIL clr_set_wins: got %0d want 1", d_ovf); end
    d_en = 1'b0;
    tick;
    nvec++; if (d_ovf !== 1'b0) begin nerr++; $display("FAIL clr_clears: got %0d want 0", d_ovf); end
    nvec++; if (d_q !== 4'd0) begin nerr++; $display("FAIL clr_hold_q: got %0d want 0", d_q); end
    d_clr = 1'b0;
  endtask

  task automatic test_hold;
    d_load = 1'b1; d_din = 4'd5;
    tick;
    d_load = 1'b0; d_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_up = ~d_up; d_din = 4'(i * 7); d_clr = ~d_clr;
      tick;
      nvec++; if (d_q !== 4'd5) begin nerr++; $display("FAIL hold_q[%0d]: got %0d want 5", i, d_q); end
      nvec++; if (d_tc !== 1'b0) begin nerr++; $display("FAIL hold_tc[%0d]: got %0d want 0", i, d_tc); end
    end
    d_clr = 1'b0;
  endtask

  task automatic test_sat_down;
    logic [3:0] exp_q   [5] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    logic       exp_tc  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    // load wins over en
    s_load = 1'b1; s_din = 4'd3; s_en = 1'b1; s_up = 1'b1;
    tick;
    nvec++; if (s_q !== 4'd3) begin nerr++; $display("FAIL sat_load_q: got %0d want 3", s_q); end
    s_load = 1'b0; s_up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      nvec++; if (s_tc !== exp_tc[i]) begin nerr++; $display("FAIL sat_tc[%0d]: got %0d want %0d", i, s_tc, exp_tc[i]); end
      tick;
      nvec++; if (s_q !== exp_q[i]) begin nerr++; $display("FAIL sat_q[%0d]: got %0d want %0d", i, s_q, exp_q[i]); end
      nvec++; if (s_ovf !== exp_ovf[i]) begin nerr++; $display("FAIL sat_ovf[%0d]: got %0d want %0d", i, s_ovf, exp_ovf[i]); end
    end
    s_en = 1'b0;
  endtask

  task automatic test_clamp;
    s_load = 1'b1; s_din = 4'd12; s_en = 1'b1; s_up = 1'b1;
    tick;
    nvec++; if (s_q !== 4'd9) begin nerr++; $display("FAIL clamp_12: got %0d want 9", s_q); end
    s_load = 1'b0;
    tick;
    nvec++; if (s_q !== 4'd9) begin nerr++; $display("FAIL clamp_sat_up: got %0d want 9", s_q); end
    s_load = 1'b1; s_din = 4'd8;
    tick;
    nvec++; if (s_q !== 4'd8) begin nerr++; $display("FAIL clamp_in_range: got %0d want 8", s_q); end
    s_load = 1'b0;
    tick;
    nvec++; if (s_q !== 4'd9) begin nerr++; $display("FAIL clamp_up_to_9: got %0d want 9", s_q); end
    s_en = 1'b0;
    w_load = 1'b1; w_din = 4'd10;
    tick;
    nvec++; if (w_q !== 4'd9) begin nerr++; $display("FAIL clamp_10: got %0d want 9", w_q); end
    w_load = 1'b0;
  endtask

  task automatic test_wrap_mod;
    w_load = 1'b1; w_din = 4'd0;
    tick;
    w_load = 1'b0; w_en = 1'b1; w_up = 1'b0;
    tick;
    nvec++; if (w_q !== 4'd9) begin nerr++; $display("FAIL mod_down_wrap_q: got %0d want 9", w_q); end
    nvec++; if (w_ovf !== 1'b1) begin nerr++; $display("FAIL mod_down_wrap_ovf: got %0d want 1", w_ovf); end
    w_up = 1'b1;
    tick;
    nvec++; if (w_q !== 4'd0) begin nerr++; $display("FAIL mod_up_wrap_q: got %0d want 0", w_q); end
    tick;
    nvec++; if (w_q !== 4'd1) begin nerr++; $display("FAIL mod_up_q: got %0d want 1", w_q); end
    w_en = 1'b0;
  endtask

  task automatic test_async_reset;
    d_load = 1'b1; d_din = 4'd15;
    tick;
    d_load = 1'b0; d_en = 1'b1; d_up = 1'b1;
    tick;
    d_en = 1'b0; d_load = 1'b1; d_din = 4'd7;
    tick;
    d_load = 1'b0;
    nvec++; if (d_q !== 4'd7 || d_ovf !== 1'b1) begin nerr++; $display("FAIL arst_setup: got q=%0d ovf=%0d want q=7 ovf=1", d_q, d_ovf); end
    #2 rst = 1'b1;
    #1;
    nvec++; if (d_q !== 4'd0) begin nerr++; $display("FAIL arst_q: got %0d want 0", d_q); end
    nvec++; if (d_ovf !== 1'b0) begin nerr++; $display("FAIL arst_ovf: got %0d want 0", d_ovf); end
    d_en = 1'b1; d_up = 1'b1;
    tick;
    nvec++; if (d_q !== 4'd0) begin nerr++; $display("FAIL arst_edge_q: got %0d want 0", d_q); end
    #2 rst = 1'b0;
    tick;
    nvec++; if (d_q !== 4'd1) begin nerr++; $display("FAIL arst_first_edge: got %0d want 1", d_q); end
    // reset arriving with a load pending discards the load
    d_en = 1'b0; d_load = 1'b1; d_din = 4'd7;
    #2 rst = 1'b1;
    tick;
    #1 rst = 1'b0;
    d_load = 1'b0;
    tick;
    nvec++; if (d_q !== 4'd0) begin nerr++; $display("FAIL arst_load_discard: got %0d want 0", d_q); end
  endtask

  task automatic test_tff;
    logic exp_q [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    nvec++; if (t_q !== 1'b0) begin nerr++; $display("FAIL tff_start: got %0d want 0", t_q); end
    t_up = 1'b1;
    for (int i = 0; i < 6; i++) begin
      t_en = (i < 4);
      tick;
      nvec++; if (t_q !== exp_q[i]) begin nerr++; $display("FAIL tff_q[%0d]: got %0d want %0d", i, t_q, exp_q[i]); end
    end
    nvec++; if (t_ovf !== 1'b1) begin nerr++; $display("FAIL tff_ovf: got %0d want 1", t_ovf); end
  endtask

  initial begin
    test_reset;
    test_wrap;
    test_clr_ovf;
    test_hold;
    test_sat_down;
    test_clamp;
    test_wrap_mod;
    test_async_reset;
    test_tff;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
